// File: rtl/count_monitor_if.sv
// rtl/count_monitor_if.sv - signal bundle between the JK counter tap and count_monitor
//
// Purpose: groups the counter tap inputs and the monitor results into one bundle.
// Signals:
//   count_enable  counter enable, tapped at the counter input
//   Q[3:0]        counter output
//   cmp_value[3:0], cmp_load   compare value and its load strobe
//   fault_ack     clears the sticky fault
//   q_s[3:0]      registered sample of Q
//   wrap, match   one-cycle event pulses
//   fault         sticky illegal-transition flag
//   wrap_cnt[7:0] saturating wrap count (zero unless COUNT_MON_WRAP_CNT_EN)
// Modports: master drives the tap and reads results; slave is the monitor.
interface count_monitor_if;
    logic       count_enable;
    logic [3:0] Q;
    logic [3:0] cmp_value;
    logic       cmp_load;
    logic       fault_ack;
    logic [3:0] q_s;
    logic       wrap;
    logic       match;
    logic       fault;
    logic [7:0] wrap_cnt;

    modport master (
        output count_enable, Q, cmp_value, cmp_load, fault_ack,
        input  q_s, wrap, match, fault, wrap_cnt
    );

    modport slave (
        input  count_enable, Q, cmp_value, cmp_load, fault_ack,
        output q_s, wrap, match, fault, wrap_cnt
    );
endinterface

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - step checker for the 4-bit JK synchronous counter
//
// Purpose: samples the counter every rising edge and checks each step. A step
// must hold when the sampled enable was low and must advance by one (mod 16)
// when it was high. Emits one-cycle wrap/match pulses and a sticky fault.
// Optional feature macro: COUNT_MON_WRAP_CNT_EN builds an 8-bit saturating
// wrap counter; without it wrap_cnt is tied to zero.
// Ports:
//   clock  system clock, rising edge
//   clear  asynchronous active-low reset, shared with the counter
//   mon    count_monitor_if.slave (tap inputs, monitor outputs)
module count_monitor (
    input  logic           clock,
    input  logic           clear,
    count_monitor_if.slave mon
);
    localparam logic [1:0] ST_RESYNC = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] q_s_q;
    logic       en_s_q;
    logic [3:0] cmp_reg_q, cmp_reg_d;
    logic       fault_q, fault_d;
    logic       wrap_q, wrap_d;
    logic       match_q, match_d;
    logic [3:0] exp_count;
    logic       step_ok;

    // Value Q must have on this edge given the previous sample and enable.
    assign exp_count = en_s_q ? q_s_q + 4'd1 : q_s_q;
    assign step_ok   = (mon.Q == exp_count);

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        wrap_d    = 1'b0;
        match_d   = 1'b0;
        // The match check below reads cmp_reg_q, so a same-edge load only
        // affects later steps.
        cmp_reg_d = mon.cmp_load ? mon.cmp_value : cmp_reg_q;
        case (state_q)
            ST_RESYNC: begin
                state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (step_ok) begin
                    // Only a counting step can pulse, so a hold on the
                    // compare value never re-fires match.
                    wrap_d  = en_s_q && (q_s_q == 4'hf);
                    match_d = en_s_q && (mon.Q == cmp_reg_q);
                end else begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                end
            end
            ST_FAULT: begin
                if (mon.fault_ack) begin
                    state_d = ST_RESYNC;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_RESYNC;
                fault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_RESYNC;
            q_s_q     <= 4'd0;
            en_s_q    <= 1'b0;
            cmp_reg_q <= 4'd0;
            fault_q   <= 1'b0;
            wrap_q    <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_s_q     <= mon.Q;
            en_s_q    <= mon.count_enable;
            cmp_reg_q <= cmp_reg_d;
            fault_q   <= fault_d;
            wrap_q    <= wrap_d;
            match_q   <= match_d;
        end
    end

`ifdef COUNT_MON_WRAP_CNT_EN
    logic [7:0] wrap_cnt_q, wrap_cnt_d;

    // Counts on the same edge that raises the wrap pulse; sticks at 255.
    assign wrap_cnt_d = (wrap_d && (wrap_cnt_q != 8'hff)) ? wrap_cnt_q + 8'd1 : wrap_cnt_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wrap_cnt_q <= 8'd0;
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign mon.wrap_cnt = wrap_cnt_q;
`else
    assign mon.wrap_cnt = 8'd0;
`endif

    assign mon.q_s   = q_s_q;
    assign mon.wrap  = wrap_q;
    assign mon.match = match_q;
    assign mon.fault = fault_q;
endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - directed self-checking bench for count_monitor
module tb_count_monitor;
    logic clock;
    logic clear;
    count_monitor_if mon_if ();

    count_monitor dut (
        .clock (clock),
        .clear (clear),
        .mon   (mon_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef COUNT_MON_WRAP_CNT_EN
    localparam int WRAPS_AFTER_RUN = 1;
    localparam int WRAPS_SATURATED = 255;
`else
    localparam int WRAPS_AFTER_RUN = 0;
    localparam int WRAPS_SATURATED = 0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int obs_wrap = 0;
    int obs_match = 0;
    int cur_q = 0;

    // Reference model: the previous sample is "trusted" once one edge has
    // passed since reset or fault_ack; a trusted step is legal when it equals
    // the arithmetic successor (or the same value when disabled).
    int m_qs = 0;
    int m_cmp = 0;
    int m_wraps = 0;
    int m_want;
    bit m_en = 0;
    bit m_wrap = 0;
    bit m_match = 0;
    bit m_fault = 0;
    bit m_trusted = 0;

    always_comb m_want = m_en ? (m_qs + 1) % 16 : m_qs;

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            m_qs <= 0; m_cmp <= 0; m_wraps <= 0; m_en <= 0;
            m_wrap <= 0; m_match <= 0; m_fault <= 0; m_trusted <= 0;
        end else begin
            m_wrap  <= 0;
            m_match <= 0;
            if (m_fault) begin
                if (mon_if.fault_ack) begin
                    m_fault   <= 0;
                    m_trusted <= 0;
                end
            end else if (!m_trusted) begin
                m_trusted <= 1;
            end else if (int'(mon_if.Q) != m_want) begin
                m_fault <= 1;
            end else if (m_en) begin
                if (m_qs == 15) begin
                    m_wrap <= 1;
                    if (m_wraps < 255) m_wraps <= m_wraps + 1;
                end
                if (int'(mon_if.Q) == m_cmp) m_match <= 1;
            end
            if (mon_if.cmp_load) m_cmp <= int'(mon_if.cmp_value);
            m_qs <= int'(mon_if.Q);
            m_en <= mon_if.count_enable;
        end
    end

    function automatic int exp_wrap_cnt();
`ifdef COUNT_MON_WRAP_CNT_EN
        return m_wraps;
`else
        return 0;
`endif
    endfunction

    task automatic check_cycle();
        n_vec++;
        if (mon_if.q_s !== 4'(m_qs) || mon_if.wrap !== m_wrap || mon_if.match !== m_match ||
            mon_if.fault !== m_fault || mon_if.wrap_cnt !== 8'(exp_wrap_cnt())) begin
            n_err++;
            $display("FAIL cycle_compare t=%0t: got q_s=%0d wrap=%0b match=%0b fault=%0b wrap_cnt=%0d, need q_s=%0d wrap=%0b match=%0b fault=%0b wrap_cnt=%0d",
                     $time, mon_if.q_s, mon_if.wrap, mon_if.match, mon_if.fault, mon_if.wrap_cnt,
                     m_qs, m_wrap, m_match, m_fault, exp_wrap_cnt());
        end
        obs_wrap  += int'(mon_if.wrap);
        obs_match += int'(mon_if.match);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, need %0d", name, act, exp);
        end
    endtask

    // One cycle: compare outputs at the falling edge, then change inputs the
    // way the counter does (away from the rising edge).
    task automatic drive(input bit clr, input bit en, input int q, input int cv,
                         input bit ld, input bit ack);
        @(negedge clock);
        check_cycle();
        clear               = clr;
        mon_if.count_enable = en;
        mon_if.Q            = 4'(q);
        mon_if.cmp_value    = 4'(cv);
        mon_if.cmp_load     = ld;
        mon_if.fault_ack    = ack;
    endtask

    task automatic cnt(input bit en);
        cur_q = (cur_q + 1) % 16;
        drive(1, en, cur_q, 0, 0, 0);
    endtask

    initial begin
        clear = 0;
        mon_if.count_enable = 0;
        mon_if.Q = 4'd9;
        mon_if.cmp_value = 4'd7;
        mon_if.cmp_load = 1;
        mon_if.fault_ack = 0;

        // Reset held with activity on the inputs.
        repeat (3) drive(0, 1, 9, 7, 1, 0);
        chk("reset_q_s", int'(mon_if.q_s), 0);
        chk("reset_fault", int'(mon_if.fault), 0);
        chk("reset_wrap_cnt", int'(mon_if.wrap_cnt), 0);

        // Release, load compare value 5, one hold edge, then count.
        drive(1, 0, 0, 5, 1, 0);
        cur_q = 0;
        drive(1, 1, 0, 0, 0, 0);
        obs_wrap = 0; obs_match = 0;
        repeat (17) cnt(1);
        cnt(1);
        chk("run_wrap_pulses", obs_wrap, 1);
        chk("run_match_pulses", obs_match, 1);
        chk("run_fault", int'(mon_if.fault), 0);
        chk("run_wrap_cnt", int'(mon_if.wrap_cnt), WRAPS_AFTER_RUN);

        // Count into 5, then hold there.
        obs_match = 0;
        cnt(1); cnt(1); cnt(0);
        repeat (4) drive(1, 0, 5, 0, 0, 0);
        chk("hold_match_pulses", obs_match, 1);
        chk("hold_fault", int'(mon_if.fault), 0);

        // Count to 3, then jump to 6.
        drive(1, 1, 5, 0, 0, 0);
        repeat (14) cnt(1);
        cur_q = 6;
        drive(1, 1, 6, 0, 0, 0);
        obs_wrap = 0; obs_match = 0;
        cnt(1);
        chk("illegal_fault", int'(mon_if.fault), 1);
        repeat (15) cnt(1);
        chk("fault_no_wrap", obs_wrap, 0);
        chk("fault_no_match", obs_match, 0);
        chk("fault_sticky", int'(mon_if.fault), 1);

        // Ack coinciding with an illegal jump, then an unchecked RESYNC jump.
        cur_q = 9;
        drive(1, 1, 9, 0, 0, 1);
        cur_q = 13;
        drive(1, 1, 13, 0, 0, 0);
        repeat (4) cnt(1);
        cur_q = (cur_q + 1) % 16;
        drive(1, 1, cur_q, 0, 0, 1);
        cnt(1);
        cnt(1);
        chk("recover_fault", int'(mon_if.fault), 0);

        // Many wraps to saturate the wrap counter.
        repeat (300 * 16) cnt(1);
        chk("sat_wrap_cnt", int'(mon_if.wrap_cnt), WRAPS_SATURATED);
        chk("sat_fault", int'(mon_if.fault), 0);

        // Clear right after a wrap edge drops everything at once.
        while (cur_q != 15) cnt(1);
        cnt(1);
        @(posedge clock);
        #2;
        chk("wrap_before_clear", int'(mon_if.wrap), 1);
        clear = 0;
        #1;
        chk("clear_wrap", int'(mon_if.wrap), 0);
        chk("clear_wrap_cnt", int'(mon_if.wrap_cnt), 0);
        chk("clear_q_s", int'(mon_if.q_s), 0);
        chk("clear_fault", int'(mon_if.fault), 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
